// File: rtl/alarm_digit_editor.sv
// Staged BCD alarm editor: cursor/inc/dec on a copy of the alarm, committed on confirm.
// Optional hold-to-repeat for increment/decrement when AUTO_REPEAT_EN is defined.
module alarm_digit_editor #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] DIGIT_MAX    = 32'h0000_5959,
`ifdef AUTO_REPEAT_EN
    parameter int          REPEAT_DELAY = 500,
    parameter int          REPEAT_RATE  = 100,
`endif
    localparam int         CUR_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int         W            = 4 * NUM_DIGITS
) (
    input  logic             signal,
    input  logic             reset,
    input  logic             load,
    input  logic             confirm,
    input  logic             moveRightBtn,
    input  logic             moveLeftBtn,
    input  logic             incrementBtn,
    input  logic             decrementBtn,
    output logic [W-1:0]     alarm_value,
    output logic [W-1:0]     edit_value,
    output logic [CUR_W-1:0] cursor,
    output logic             editing,
    output logic             commit_pulse
);
    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

    state_t           state_q;
    logic [W-1:0]     alarm_q, edit_q, edit_d;
    logic [CUR_W-1:0] cur_q, cur_d;
    logic [4:0]       btn, hist_q, ev;
    logic             inc_step, dec_step;
    logic [3:0]       dig, mx;

    // Bit order: {dec, inc, left, right, confirm}
    assign btn = {decrementBtn, incrementBtn, moveLeftBtn, moveRightBtn, confirm};
    assign ev  = btn & ~hist_q;

`ifdef AUTO_REPEAT_EN
    logic [31:0] rep_cnt_q;
    logic        rep_arm_q, rep_first_q, rep_held, rep_fire;

    // Only a single-button hold that began with an edge event in EDIT repeats.
    assign rep_held = (incrementBtn & ~decrementBtn & hist_q[3]) |
                      (decrementBtn & ~incrementBtn & hist_q[4]);
    assign rep_fire = rep_arm_q && rep_held &&
                      (rep_cnt_q + 32'd1 == 32'(rep_first_q ? REPEAT_DELAY : REPEAT_RATE));
    assign inc_step = ev[3] | (rep_fire & incrementBtn);
    assign dec_step = ev[4] | (rep_fire & decrementBtn);

    always_ff @(posedge signal or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b0;
        end else if (state_q != S_EDIT) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else if ((ev[3] & ~decrementBtn) | (ev[4] & ~incrementBtn)) begin
            rep_cnt_q   <= '0;
            rep_arm_q   <= 1'b1;
            rep_first_q <= 1'b1;
        end else if (rep_arm_q && rep_held) begin
            if (rep_fire) begin
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b0;
            end else begin
                rep_cnt_q <= rep_cnt_q + 32'd1;
            end
        end else begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end
    end
`else
    assign inc_step = ev[3];
    assign dec_step = ev[4];
`endif

    always_comb begin
        edit_d = edit_q;
        dig    = '0;
        mx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CUR_W'(i) == cur_q) begin
                dig = edit_q[4*i +: 4];
                mx  = DIGIT_MAX[4*i +: 4];
                if (inc_step && !dec_step)
                    edit_d[4*i +: 4] = (dig == mx) ? 4'd0 : dig + 4'd1;
                else if (dec_step && !inc_step)
                    edit_d[4*i +: 4] = (dig == 4'd0) ? mx : dig - 4'd1;
            end
        end
    end

    always_comb begin
        cur_d = cur_q;
        if (ev[2] && !ev[1])
            cur_d = (cur_q == CUR_W'(NUM_DIGITS - 1)) ? '0 : cur_q + 1'b1;
        else if (ev[1] && !ev[2])
            cur_d = (cur_q == '0) ? CUR_W'(NUM_DIGITS - 1) : cur_q - 1'b1;
    end

    always_ff @(posedge signal or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            alarm_q <= '0;
            edit_q  <= '0;
            cur_q   <= '0;
            hist_q  <= '0;
        end else begin
            hist_q <= btn;
            case (state_q)
                S_IDLE: if (load) begin
                    state_q <= S_EDIT;
                    edit_q  <= alarm_q;
                    cur_q   <= '0;
                end
                S_EDIT: begin
                    if (!load) begin
                        state_q <= S_IDLE;
                    end else if (ev[0]) begin
                        state_q <= S_COMMIT;
                        edit_q  <= edit_d;
                        alarm_q <= edit_d;
                    end else begin
                        edit_q <= edit_d;
                        cur_q  <= cur_d;
                    end
                end
                S_COMMIT: state_q <= load ? S_EDIT : S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign alarm_value  = alarm_q;
    assign edit_value   = edit_q;
    assign cursor       = cur_q;
    assign editing      = (state_q == S_EDIT);
    assign commit_pulse = (state_q == S_COMMIT);
endmodule
